// File: rtl/weight_sparse_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : weight_sparse_encoder
//  Purpose  : Converts a dense convolution weight tile (k-major, then r, then
//             s) into a compressed sparse stream. Each kept weight becomes one
//             (value, r, s, k) entry. The module also emits a per-filter
//             start pointer and the total entry count.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_rst        clock, synchronous active-high reset
//    i_start             one-cycle pulse that begins a tile (IDLE only)
//    i_w / i_w_valid     dense weight input
//    o_w_ready           encoder can accept a weight
//    i_thresh            prune threshold, unsigned (macro builds only)
//    o_val/o_r/o_s/o_k   entry payload
//    o_valid / i_ready   entry handshake
//    o_ptr / o_ptr_valid index of the first entry of each filter (pulse)
//    o_length            entries kept, updated on tile completion
//    o_overflow          entries were dropped this tile
//    o_finish            one-cycle tile-complete pulse
//  Build option
//    WENC_PRUNE_THRESH_EN : adds i_thresh; weights with |w| <= threshold
//                           are dropped. Otherwise only exact zeros drop.
// ============================================================================
module weight_sparse_encoder #(
  parameter int W_BITWIDTH = 8,
  parameter int KR         = 3,
  parameter int KS         = 3,
  parameter int KN         = 8,
  parameter int MAX_NNZ    = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [W_BITWIDTH-1:0]        i_w,
  input  logic                         i_w_valid,
  output logic                         o_w_ready,
`ifdef WENC_PRUNE_THRESH_EN
  input  logic [W_BITWIDTH-1:0]        i_thresh,
`endif
  output logic [W_BITWIDTH-1:0]        o_val,
  output logic [$clog2(KR)-1:0]        o_r,
  output logic [$clog2(KS)-1:0]        o_s,
  output logic [$clog2(KN)-1:0]        o_k,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(MAX_NNZ):0]     o_ptr,
  output logic                         o_ptr_valid,
  output logic [$clog2(MAX_NNZ):0]     o_length,
  output logic                         o_overflow,
  output logic                         o_finish
);

  localparam int RW = $clog2(KR);
  localparam int SW = $clog2(KS);
  localparam int KW = $clog2(KN);
  localparam int NW = $clog2(MAX_NNZ) + 1;
  localparam int EW = W_BITWIDTH + RW + SW + KW;

  localparam logic [RW-1:0] c_R_LAST  = RW'(KR - 1);
  localparam logic [SW-1:0] c_S_LAST  = SW'(KS - 1);
  localparam logic [KW-1:0] c_K_LAST  = KW'(KN - 1);
  localparam logic [NW-1:0] c_NNZ_MAX = NW'(MAX_NNZ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [RW-1:0]     r_r;
  logic [SW-1:0]     r_s;
  logic [KW-1:0]     r_k;
  logic [NW-1:0]     r_nnz;
  logic [NW-1:0]     r_ptr;
  logic              r_ptr_valid;
  logic [NW-1:0]     r_length;
  logic              r_overflow;

  // Two-entry output buffer; slot 0 is always the head and drives the outputs.
  logic [EW-1:0]     r_slot0;
  logic [EW-1:0]     r_slot1;
  logic [1:0]        r_cnt;

  logic              w_w_ready;
  logic              w_xfer;
  logic              w_nz;
  logic              w_first;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [EW-1:0]     w_new;

  // --------------------------------------------------------------------------
  // Zero / prune test
  // --------------------------------------------------------------------------
`ifdef WENC_PRUNE_THRESH_EN
  logic [W_BITWIDTH-1:0] r_thresh;
  logic [W_BITWIDTH:0]   w_mag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_thresh <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_thresh <= i_thresh;
    end
  end

  // One extra bit so the most negative weight has a representable magnitude.
  assign w_mag = i_w[W_BITWIDTH-1] ? ({1'b0, ~i_w} + (W_BITWIDTH+1)'(1))
                                   : {1'b0, i_w};
  assign w_nz  = (w_mag > {1'b0, r_thresh});
`else
  assign w_nz  = |i_w;
`endif

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // A full buffer still accepts when the head leaves on the same edge.
  assign w_w_ready = (r_state == S_RUN) && ((r_cnt != 2'd2) || i_ready);
  assign o_w_ready = w_w_ready;
  assign w_xfer    = i_w_valid && w_w_ready;
  assign w_first   = (r_r == '0) && (r_s == '0);
  assign w_last    = (r_k == c_K_LAST) && (r_r == c_R_LAST) && (r_s == c_S_LAST);
  assign w_pop     = (r_cnt != 2'd0) && i_ready;
  assign w_push    = w_xfer && w_nz && (r_nnz != c_NNZ_MAX);
  assign w_drop    = w_xfer && w_nz && (r_nnz == c_NNZ_MAX);
  assign w_new     = {i_w, r_r, r_s, r_k};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_finish    = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_xfer && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == 2'd0) w_state_nxt = S_DONE;
      S_DONE: begin
        o_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Coordinates, counters, pointer and output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r         <= '0;
      r_s         <= '0;
      r_k         <= '0;
      r_nnz       <= '0;
      r_ptr       <= '0;
      r_ptr_valid <= 1'b0;
      r_length    <= '0;
      r_overflow  <= 1'b0;
      r_slot0     <= '0;
      r_slot1     <= '0;
      r_cnt       <= 2'd0;
    end else begin
      r_ptr_valid <= 1'b0;

      if (r_state == S_IDLE && i_start) begin
        r_r        <= '0;
        r_s        <= '0;
        r_k        <= '0;
        r_nnz      <= '0;
        r_length   <= '0;
        r_overflow <= 1'b0;
      end

      if (w_xfer) begin
        if (r_s == c_S_LAST) begin
          r_s <= '0;
          if (r_r == c_R_LAST) begin
            r_r <= '0;
            r_k <= (r_k == c_K_LAST) ? '0 : r_k + KW'(1);
          end else begin
            r_r <= r_r + RW'(1);
          end
        end else begin
          r_s <= r_s + SW'(1);
        end

        // Pointer reports the entry count before this filter's first weight.
        if (w_first) begin
          r_ptr_valid <= 1'b1;
          r_ptr       <= r_nnz;
        end
        if (w_push) r_nnz      <= r_nnz + NW'(1);
        if (w_drop) r_overflow <= 1'b1;
      end

      if (r_state == S_DRAIN && r_cnt == 2'd0) begin
        r_length <= r_nnz;
      end

      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_slot0 <= w_new;
            r_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_slot0 <= w_new;
          end else if (w_push) begin
            r_slot1 <= w_new;
            r_cnt   <= 2'd2;
          end else if (w_pop) begin
            r_cnt   <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_slot0 <= r_slot1;
            if (w_push) begin
              r_slot1 <= w_new;
            end else begin
              r_cnt   <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign {o_val, o_r, o_s, o_k} = r_slot0;
  assign o_valid     = (r_cnt != 2'd0);
  assign o_ptr       = r_ptr;
  assign o_ptr_valid = r_ptr_valid;
  assign o_length    = r_length;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_weight_sparse_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_sparse_encoder
//  Purpose  : Self-checking bench for weight_sparse_encoder. Directed and
//             random tiles are compared against a behavioural model that
//             derives entries, pointers, length and overflow from the dense
//             tile with plain arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_weight_sparse_encoder;

  localparam int W_BITWIDTH = 8;
  localparam int KR = 3;
  localparam int KS = 3;
  localparam int KN = 8;
  localparam int MAX_NNZ = 64;
  localparam int NWT = KR * KS * KN;
  localparam int RW = $clog2(KR);
  localparam int SW = $clog2(KS);
  localparam int KW = $clog2(KN);
  localparam int PW = $clog2(MAX_NNZ) + 1;

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_start;
  logic [W_BITWIDTH-1:0] i_w;
  logic                  i_w_valid;
  logic                  o_w_ready;
`ifdef WENC_PRUNE_THRESH_EN
  logic [W_BITWIDTH-1:0] i_thresh;
`endif
  logic [W_BITWIDTH-1:0] o_val;
  logic [RW-1:0]         o_r;
  logic [SW-1:0]         o_s;
  logic [KW-1:0]         o_k;
  logic                  o_valid;
  logic                  i_ready;
  logic [PW-1:0]         o_ptr;
  logic                  o_ptr_valid;
  logic [PW-1:0]         o_length;
  logic                  o_overflow;
  logic                  o_finish;

  weight_sparse_encoder #(
    .W_BITWIDTH(W_BITWIDTH), .KR(KR), .KS(KS), .KN(KN), .MAX_NNZ(MAX_NNZ)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_w(i_w),
    .i_w_valid(i_w_valid),
    .o_w_ready(o_w_ready),
`ifdef WENC_PRUNE_THRESH_EN
    .i_thresh(i_thresh),
`endif
    .o_val(o_val),
    .o_r(o_r),
    .o_s(o_s),
    .o_k(o_k),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_ptr(o_ptr),
    .o_ptr_valid(o_ptr_valid),
    .o_length(o_length),
    .o_overflow(o_overflow),
    .o_finish(o_finish)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pack(input int v, input int r, input int s, input int k);
    return ((v & ((1 << W_BITWIDTH) - 1)) << (RW + SW + KW)) | (r << (SW + KW)) | (s << KW) | k;
  endfunction

  // ---------------------------------------------------------------- monitor
  int   got_q[$];
  int   ptr_q[$];
  int   fin_cnt = 0;
  int   fin_len = 0;
  int   fin_ovf = 0;
  int   fin_cyc = 0;
  int   rise_cyc = -1;
  int   bad_stall = 0;
  int   stall_seen = 0;
  int   unstable = 0;
  bit   prev_hold = 0;
  bit   prev_valid = 0;
  int   prev_ent = 0;
  int   m_ent;

  initial forever begin
    @(negedge i_clk);
    m_ent = pack(int'(o_val), int'(o_r), int'(o_s), int'(o_k));
    if (prev_hold && m_ent != prev_ent) unstable++;
    prev_hold = o_valid && !i_ready && !i_rst;
    prev_ent  = m_ent;
    if (o_valid && i_ready) got_q.push_back(m_ent);
    if (o_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = o_valid;
    if (o_ptr_valid) ptr_q.push_back(int'(o_ptr));
    if (o_finish) begin
      fin_cnt++;
      fin_len = int'(o_length);
      fin_ovf = int'(o_overflow);
      fin_cyc = cyc;
    end
    if (i_w_valid && i_ready && !o_w_ready && !i_rst) bad_stall++;
    if (i_w_valid && !i_ready && !o_w_ready) stall_seen++;
  end

  // ---------------------------------------------------------------- model
  int tw[NWT];
  int xcyc[NWT];
  int exp_q[$];
  int exp_ptr[$];
  int exp_len;
  int exp_ovf;
  int cur_thresh = 0;

  function automatic bit is_kept(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return a > cur_thresh;
  endfunction

  task automatic model();
    int nnz;
    nnz = 0;
    exp_ovf = 0;
    exp_q.delete();
    exp_ptr.delete();
    for (int idx = 0; idx < NWT; idx++) begin
      int k, r, s;
      k = idx / (KR * KS);
      r = (idx / KS) % KR;
      s = idx % KS;
      if (r == 0 && s == 0) exp_ptr.push_back(nnz);
      if (is_kept(tw[idx])) begin
        if (nnz < MAX_NNZ) begin
          exp_q.push_back(pack(tw[idx], r, s, k));
          nnz++;
        end else begin
          exp_ovf = 1;
        end
      end
    end
    exp_len = nnz;
  endtask

  task automatic gen_random(input int density);
    for (int i = 0; i < NWT; i++) begin
      int v;
      v = int'($urandom_range(1, 255));
      if (v > 127) v -= 256;
      tw[i] = (int'($urandom_range(0, 99)) < density) ? v : 0;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  bit w_done = 0;
  bit bubble_en = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_weights(input int first, input int last, input int ign_idx);
    for (int idx = first; idx <= last; idx++) begin
      bit took;
      int guard;
      if (bubble_en && $urandom_range(0, 3) == 0) begin
        i_w_valid = 1'b0;
        i_w = W_BITWIDTH'($urandom);
        repeat ($urandom_range(1, 2)) step();
      end
      i_w = W_BITWIDTH'(tw[idx]);
      i_w_valid = 1'b1;
      i_start = (idx == ign_idx);
      took = 0;
      guard = 0;
      while (!took && guard < 500) begin
        @(negedge i_clk);
        took = o_w_ready;
        if (took) xcyc[idx] = cyc;
        step();
        i_start = 1'b0;
        guard++;
      end
      if (!took) begin
        chk("xfer_timeout", 0, 1);
        i_w_valid = 1'b0;
        return;
      end
    end
    i_w_valid = 1'b0;
  endtask

  task automatic drive_ready(input int mode);
    int n;
    n = 0;
    while (!w_done) begin
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(0, 9) < 7);
        default: i_ready = !(n >= 10 && n <= 14);
      endcase
      step();
      n++;
    end
    i_ready = 1'b1;
  endtask

  task automatic run_tile(input string tag, input int mode, input int ign_idx);
    int b_got, b_ptr, b_fin, b_bad, b_unst, b_stall, guard, n;
    model();
    b_got = got_q.size();
    b_ptr = ptr_q.size();
    b_fin = fin_cnt;
    b_bad = bad_stall;
    b_unst = unstable;
    b_stall = stall_seen;
`ifdef WENC_PRUNE_THRESH_EN
    i_thresh = W_BITWIDTH'(cur_thresh);
`endif
    i_start = 1'b1;
    step();
    i_start = 1'b0;
`ifdef WENC_PRUNE_THRESH_EN
    i_thresh = W_BITWIDTH'($urandom);
`endif
    w_done = 0;
    fork
      begin
        run_weights(0, NWT - 1, ign_idx);
        w_done = 1;
      end
      drive_ready(mode);
    join
    guard = 0;
    while (fin_cnt == b_fin && guard < 400) begin
      step();
      guard++;
    end
    repeat (3) step();
    chk({tag, ".finish_pulses"}, fin_cnt - b_fin, 1);
    n = got_q.size() - b_got;
    chk({tag, ".entry_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s.entry%0d", tag, i), got_q[b_got + i], exp_q[i]);
    n = ptr_q.size() - b_ptr;
    chk({tag, ".ptr_count"}, n, KN);
    for (int i = 0; i < n && i < exp_ptr.size(); i++)
      chk($sformatf("%s.ptr%0d", tag, i), ptr_q[b_ptr + i], exp_ptr[i]);
    chk({tag, ".length"}, fin_len, exp_len);
    chk({tag, ".overflow"}, fin_ovf, exp_ovf);
    chk({tag, ".length_held"}, int'(o_length), exp_len);
    chk({tag, ".ready_stall"}, bad_stall - b_bad, 0);
    chk({tag, ".payload_stable"}, unstable - b_unst, 0);
    if (mode == 2) chk({tag, ".backpressure"}, (stall_seen > b_stall) ? 1 : 0, 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int b_fin;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_w = '0;
    i_w_valid = 1'b0;
    i_ready = 1'b1;
`ifdef WENC_PRUNE_THRESH_EN
    i_thresh = '0;
`endif
    repeat (3) step();
    i_rst = 1'b0;
    i_w_valid = 1'b1;
    @(negedge i_clk);
    chk("reset.o_valid", int'(o_valid), 0);
    chk("reset.o_w_ready_idle", int'(o_w_ready), 0);
    chk("reset.o_ptr_valid", int'(o_ptr_valid), 0);
    chk("reset.o_ptr", int'(o_ptr), 0);
    chk("reset.o_length", int'(o_length), 0);
    chk("reset.o_overflow", int'(o_overflow), 0);
    chk("reset.o_finish", int'(o_finish), 0);
    chk("reset.payload", pack(int'(o_val), int'(o_r), int'(o_s), int'(o_k)), 0);
    step();
    i_w_valid = 1'b0;

    // All-zero tile: no entries, all pointers 0, finish two cycles after the end.
    for (int i = 0; i < NWT; i++) tw[i] = 0;
    run_tile("zero", 0, -1);
    chk("zero.finish_latency", fin_cyc - xcyc[NWT-1], 2);

    // Single -5 at k=2, r=1, s=2.
    for (int i = 0; i < NWT; i++) tw[i] = 0;
    tw[2*9 + 1*3 + 2] = -5;
    run_tile("single", 0, -1);
    chk("single.valid_latency", rise_cyc - xcyc[23], 1);

    // Alternating 7/0 with a backpressure window.
    for (int i = 0; i < NWT; i++) tw[i] = (i % 2 == 0) ? 7 : 0;
    run_tile("alt", 2, -1);

    // All ones: saturation at capacity.
    for (int i = 0; i < NWT; i++) tw[i] = 1;
    run_tile("ones", 0, -1);

    // Random tiles with bubbles and random backpressure; one stray start.
    bubble_en = 1;
    gen_random(50);
    run_tile("rand50", 1, -1);
    gen_random(90);
    run_tile("rand90", 1, 30);
    gen_random(20);
    run_tile("rand20", 0, -1);
    bubble_en = 0;

    // Reset mid-tile with two entries pending.
    for (int i = 0; i < NWT; i++) tw[i] = 1;
    i_ready = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    run_weights(0, 18, -1);
    i_ready = 1'b0;
    run_weights(19, 19, -1);
    @(negedge i_clk);
    chk("rst_mid.pending", int'(o_valid), 1);
    b_fin = fin_cnt;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid.o_valid", int'(o_valid), 0);
    chk("rst_mid.o_w_ready", int'(o_w_ready), 0);
    chk("rst_mid.o_ptr", int'(o_ptr), 0);
    chk("rst_mid.payload", pack(int'(o_val), int'(o_r), int'(o_s), int'(o_k)), 0);
    chk("rst_mid.o_length", int'(o_length), 0);
    step();
    i_ready = 1'b1;
    repeat (20) step();
    chk("rst_mid.no_finish", fin_cnt - b_fin, 0);
    bubble_en = 1;
    gen_random(60);
    run_tile("post_rst", 1, -1);
    bubble_en = 0;

`ifdef WENC_PRUNE_THRESH_EN
    cur_thresh = 2;
    for (int i = 0; i < NWT; i++) tw[i] = 0;
    tw[0] = 1;
    tw[1] = -2;
    tw[2] = 3;
    tw[3] = -3;
    run_tile("thresh2", 0, -1);
    cur_thresh = int'($urandom_range(0, 40));
    gen_random(70);
    run_tile("thresh_rand", 1, -1);
    cur_thresh = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
